// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BTB + 2-bit counter next-PC prediction,
// and the registered {pc, inst, predTaken} hand-off to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    input  logic        updateValid,
    input  logic [31:0] updatePc,
    input  logic        updateTaken,
    input  logic [31:0] updateTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] outPc,
    output logic [31:0] outInst,
    output logic        outPredTaken
);

    localparam int          IDX  = $clog2(BTB_ENTRIES);
    localparam int          TAGW = 30 - IDX;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0]     pc;

    logic            btbValid  [BTB_ENTRIES];
    logic [TAGW-1:0] btbTag    [BTB_ENTRIES];
    logic [29:0]     btbTarget [BTB_ENTRIES];
    logic [1:0]      btbCnt    [BTB_ENTRIES];

    logic [IDX-1:0]  lookIdx;
    logic [TAGW-1:0] lookTag;
    logic [IDX-1:0]  updIdx;
    logic [TAGW-1:0] updTag;
    logic            lookHit;
    logic            updHit;
    logic            predTaken;
    logic [31:0]     predTarget;
    logic [31:0]     nextSeqPc;

    // Low address bits are word-alignment only; they never reach state.
    logic unusedLowBits;
    assign unusedLowBits = ^{redirectPc[1:0], updatePc[1:0], updateTarget[1:0]};

    assign imemAddr = pc;

    always_comb begin
        lookIdx    = pc[IDX+1:2];
        lookTag    = pc[31:IDX+2];
        updIdx     = updatePc[IDX+1:2];
        updTag     = updatePc[31:IDX+2];
        lookHit    = btbValid[lookIdx] && (btbTag[lookIdx] == lookTag);
        updHit     = btbValid[updIdx] && (btbTag[updIdx] == updTag);
        predTaken  = lookHit && btbCnt[lookIdx][1];
        predTarget = {btbTarget[lookIdx], 2'b00};
        nextSeqPc  = pc + 32'd4;
    end

    // Redirect beats stall: a mispredict must squash even a stalled wrong-path fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= {RESET_PC[31:2], 2'b00};
            outPc        <= 32'h0;
            outInst      <= NOP;
            outPredTaken <= 1'b0;
        end else if (redirectValid) begin
            pc           <= {redirectPc[31:2], 2'b00};
            outPc        <= 32'h0;
            outInst      <= NOP;
            outPredTaken <= 1'b0;
        end else if (!stall) begin
            outPc        <= pc;
            outInst      <= imemData;
            outPredTaken <= predTaken;
            pc           <= predTaken ? predTarget : nextSeqPc;
        end
    end

    // Training runs independently of stall/redirect; a taken miss evicts the occupant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btbValid[i] <= 1'b0;
                btbCnt[i]   <= 2'b01;
            end
        end else if (updateValid) begin
            if (updHit) begin
                if (updateTaken) begin
                    if (btbCnt[updIdx] != 2'b11) begin
                        btbCnt[updIdx] <= btbCnt[updIdx] + 2'd1;
                    end
                    btbTarget[updIdx] <= updateTarget[31:2];
                end else if (btbCnt[updIdx] != 2'b00) begin
                    btbCnt[updIdx] <= btbCnt[updIdx] - 2'd1;
                end
            end else if (updateTaken) begin
                btbValid[updIdx]  <= 1'b1;
                btbTag[updIdx]    <= updTag;
                btbTarget[updIdx] <= updateTarget[31:2];
                btbCnt[updIdx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented corner cases,
// then random traffic checked against an arithmetic model of fetch + predictor.
module tb_fetch_stage;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst, stall, redirectValid, updateValid, updateTaken;
    logic [31:0] redirectPc, updatePc, updateTarget;
    logic [31:0] imemAddr, imemData, outPc, outInst;
    logic        outPredTaken;

    int nVectors     = 0;
    int nChecks      = 0;
    int nMiscompares = 0;

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] uPc;
        logic        uTaken;
        logic [31:0] uTgt;
        logic [31:0] eAddr, ePc;
        logic        eBubble, ePred;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] mPc, mOutPc, mOutInst;
    logic        mOutPred;
    bit          mValid [N];
    logic [31:0] mTag   [N];
    logic [31:0] mTgt   [N];
    int          mCnt   [N];

    fetch_stage #(.RESET_PC(32'h0), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .updateValid(updateValid), .updatePc(updatePc),
        .updateTaken(updateTaken), .updateTarget(updateTarget),
        .imemAddr(imemAddr), .imemData(imemData),
        .outPc(outPc), .outInst(outInst), .outPredTaken(outPredTaken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imemData = memWord(imemAddr);

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    task automatic addVec(input logic r, s, rd, input logic [31:0] rpc,
                          input logic u, input logic [31:0] uPc, input logic uT,
                          input logic [31:0] uTgt, input logic [31:0] eAddr, ePc,
                          input logic eBub, ePred);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc;
        v.upd = u; v.uPc = uPc; v.uTaken = uT; v.uTgt = uTgt;
        v.eAddr = eAddr; v.ePc = ePc; v.eBubble = eBub; v.ePred = ePred;
        vecs.push_back(v);
    endtask

    task automatic modelStep(input vec_t v);
        int          li, ui;
        bit          pt, uHit;
        logic [31:0] ptg;
        li  = idxOf(mPc);
        pt  = mValid[li] && (mTag[li] == tagOf(mPc)) && (mCnt[li] >= 2);
        ptg = mTgt[li];
        if (v.rst) begin
            mPc = 32'h0; mOutPc = 32'h0; mOutInst = 32'h13; mOutPred = 1'b0;
            for (int i = 0; i < N; i++) begin
                mValid[i] = 1'b0; mCnt[i] = 1;
            end
        end else begin
            if (v.upd) begin
                ui   = idxOf(v.uPc);
                uHit = mValid[ui] && (mTag[ui] == tagOf(v.uPc));
                if (uHit && v.uTaken) begin
                    mCnt[ui] = (mCnt[ui] < 3) ? mCnt[ui] + 1 : 3;
                    mTgt[ui] = v.uTgt & ~32'h3;
                end else if (uHit) begin
                    mCnt[ui] = (mCnt[ui] > 0) ? mCnt[ui] - 1 : 0;
                end else if (v.uTaken) begin
                    mValid[ui] = 1'b1; mTag[ui] = tagOf(v.uPc);
                    mTgt[ui] = v.uTgt & ~32'h3; mCnt[ui] = 2;
                end
            end
            if (v.redir) begin
                mPc = v.rpc & ~32'h3;
                mOutPc = 32'h0; mOutInst = 32'h13; mOutPred = 1'b0;
            end else if (!v.stall) begin
                mOutPc = mPc; mOutInst = memWord(mPc); mOutPred = pt;
                mPc = pt ? ptg : mPc + 32'd4;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; stall = v.stall; redirectValid = v.redir; redirectPc = v.rpc;
        updateValid = v.upd; updatePc = v.uPc; updateTaken = v.uTaken; updateTarget = v.uTgt;
        @(posedge clk);
        #1;
        nVectors++;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, exp);
        nChecks++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s vec %0d: got %08h expected %08h", nm, nVectors, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectPc = 32'h0;
        updateValid = 1'b0; updatePc = 32'h0; updateTaken = 1'b0; updateTarget = 32'h0;

        //     rst s rd rpc          u uPc    uT uTgt     eAddr        ePc          bub pred
        addVec(1, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h0,       32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h4,       32'h0,       0, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h8,       32'h4,       0, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'hC,       32'h8,       0, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h10,      32'hC,       0, 0);
        addVec(0, 0, 1, 32'h103,     0, 32'h0,  0, 32'h0,   32'h100,     32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h104,     32'h100,     0, 0);
        addVec(0, 0, 1, 32'h1C,      0, 32'h0,  0, 32'h0,   32'h1C,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h20,      32'h1C,      0, 0);
        addVec(0, 1, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h20,      32'h1C,      0, 0);
        addVec(0, 1, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h20,      32'h1C,      0, 0);
        addVec(0, 1, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h20,      32'h1C,      0, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h24,      32'h20,      0, 0);
        addVec(0, 1, 1, 32'h200,     0, 32'h0,  0, 32'h0,   32'h200,     32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       1, 32'h40, 1, 32'h80,  32'h204,     32'h200,     0, 0);
        addVec(0, 0, 1, 32'h40,      0, 32'h0,  0, 32'h0,   32'h40,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h80,      32'h40,      0, 1);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h84,      32'h80,      0, 0);
        addVec(0, 0, 0, 32'h0,       1, 32'h40, 0, 32'h0,   32'h88,      32'h84,      0, 0);
        addVec(0, 0, 0, 32'h0,       1, 32'h40, 0, 32'h0,   32'h8C,      32'h88,      0, 0);
        addVec(0, 0, 1, 32'h40,      0, 32'h0,  0, 32'h0,   32'h40,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h44,      32'h40,      0, 0);
        addVec(0, 0, 0, 32'h0,       1, 32'h40, 1, 32'h80,  32'h48,      32'h44,      0, 0);
        addVec(0, 0, 0, 32'h0,       1, 32'h40, 1, 32'h80,  32'h4C,      32'h48,      0, 0);
        addVec(0, 0, 1, 32'h40,      0, 32'h0,  0, 32'h0,   32'h40,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h80,      32'h40,      0, 1);
        addVec(0, 0, 0, 32'h0,       1, 32'h80, 1, 32'h300, 32'h84,      32'h80,      0, 0);
        addVec(0, 0, 1, 32'h40,      0, 32'h0,  0, 32'h0,   32'h40,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h44,      32'h40,      0, 0);
        addVec(0, 0, 1, 32'h80,      0, 32'h0,  0, 32'h0,   32'h80,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h300,     32'h80,      0, 1);
        addVec(1, 0, 0, 32'h0,       1, 32'h80, 1, 32'h300, 32'h0,       32'h0,       1, 0);
        addVec(0, 0, 1, 32'h80,      0, 32'h0,  0, 32'h0,   32'h80,      32'h0,       1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h84,      32'h80,      0, 0);
        addVec(0, 0, 1, 32'hFFFFFFFF, 0, 32'h0, 0, 32'h0,   32'hFFFFFFFC, 32'h0,      1, 0);
        addVec(0, 0, 0, 32'h0,       0, 32'h0,  0, 32'h0,   32'h0,       32'hFFFFFFFC, 0, 0);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("dirImemAddr", imemAddr, vecs[i].eAddr);
            checkOutput("dirOutPc", outPc, vecs[i].ePc);
            checkOutput("dirOutInst", outInst,
                        vecs[i].eBubble ? 32'h13 : memWord(vecs[i].ePc));
            checkOutput("dirOutPred", {31'b0, outPredTaken}, {31'b0, vecs[i].ePred});
        end

        // Random traffic in a small address window so the BTB sees hits and aliasing.
        for (int i = 0; i < 3000; i++) begin
            v.rst    = (i == 0) || ($urandom_range(0, 199) == 0);
            v.stall  = ($urandom_range(0, 4) == 0);
            v.redir  = ($urandom_range(0, 7) == 0);
            v.rpc    = $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
            v.upd    = ($urandom_range(0, 2) == 0);
            v.uPc    = ($urandom_range(0, 1) == 0) ? mPc : $urandom_range(0, 255) * 4;
            v.uTaken = ($urandom_range(0, 2) != 0);
            v.uTgt   = $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
            v.eAddr  = 32'h0; v.ePc = 32'h0; v.eBubble = 1'b0; v.ePred = 1'b0;
            modelStep(v);
            applyStimulus(v);
            checkOutput("rndImemAddr", imemAddr, mPc);
            checkOutput("rndOutPc", outPc, mOutPc);
            checkOutput("rndOutInst", outInst, mOutInst);
            checkOutput("rndOutPred", {31'b0, outPredTaken}, {31'b0, mOutPred});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the in-order RISC-V pipeline, and the producer end of the fetch→decode pipeline interface. Each cycle it:
- drives the PC to instruction memory;
- predicts the next PC with a small direct-mapped BTB and 2-bit counters;
- registers {pc, inst, predicted-taken} for decode.

It honours the data-hazard stall from the controller and the branch-mispredict redirect from execute, and trains its predictor from resolved branches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- BTB_ENTRIES, 16, number of predictor entries; power of two, 2..64.

Ports (IDX = log2(BTB_ENTRIES)):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  data hazard from controller; hold PC and output register.
- redirectValid  in  1  branch mispredict resolved in execute.
- redirectPc  in  32  correct next PC; bits [1:0] ignored (treated as 0).
- updateValid  in  1  a branch/jump resolved this cycle; train predictor.
- updatePc  in  32  PC of the resolved branch.
- updateTaken  in  1  actual direction.
- updateTarget  in  32  actual taken target.
- imemAddr  out  32  fetch address = PC register (combinational).
- imemData  in  32  instruction word at imemAddr, valid in the same cycle.
- outPc  out  32  registered PC for decode.
- outInst  out  32  registered instruction for decode.
- outPredTaken  out  1  registered prediction for decode.

## Operation
PC register (`pc`):
- Reset value: RESET_PC.
- Bits [1:0] are always 0.

Next-PC and output-register priority, highest first:
- **rst:**
  - pc <= RESET_PC.
  - Output register <= bubble (outPc=0, outInst=32'h0000_0013 (NOP), outPredTaken=0).
  - All BTB valid bits <= 0; all counters <= 2'b01.
- **redirectValid** (overrides stall):
  - pc <= {redirectPc[31:2],2'b00}.
  - Output register <= bubble; the word fetched this cycle is wrong-path.
- **stall:** pc, outPc, outInst and outPredTaken hold.
- **Normal:**
  - Output register <= {pc, imemData, predTaken}.
  - pc <= predTaken ? predTarget : pc+4. pc+4 wraps modulo 2^32.

Lookup (combinational on pc):
- index = pc[IDX+1:2]; tag = pc[31:IDX+2].
- hit = valid[index] && tag matches.
- predTaken = hit && counter[index][1]; predTarget = target[index].

Update (at the clock edge, when updateValid=1; index and tag taken from updatePc):
- Hit:
  - Counter saturating +1 if taken, -1 if not, range 0..3.
  - If taken, target <= updateTarget.
- Miss and taken: allocate the entry, overwriting any previous occupant.
  - valid=1, tag set, target=updateTarget, counter=2'b10.
- Miss and not taken: no change.
- Updates proceed regardless of stall and redirect, but not during rst.

Simultaneous events:
- Lookup and update to the same index in one cycle: the lookup sees pre-update state.
- Redirect and updateValid in the same cycle: both take effect.

## Timing
- Fetch latency is 1 cycle: the word at pc in cycle N appears on out* in cycle N+1.
- Redirect asserted in cycle N:
  - cycle N+1: bubble on out*, imemAddr = redirectPc;
  - cycle N+2: instruction at redirectPc on out*.
- Stall asserted in cycle N: out* and imemAddr in N+1 equal their N values. Throughput resumes the cycle after stall drops.
- An update at edge N affects predictions from cycle N+1 onward.
- Reset mid-stream: the cycle after rst, imemAddr=RESET_PC and out* = bubble. Predictor state from before reset is fully discarded.

## Test plan
- **Reset, then free-run with no BTB hits, RESET_PC=0:**
  - imemAddr sequence 0,4,8,…;
  - outPc lags imemAddr by 1 cycle;
  - outInst = the imem word fetched in the previous cycle; outPredTaken=0;
  - first cycle after reset, out* = bubble (inst 0x00000013).
- **Redirect at PC 0x10, redirectPc=0x103 (misaligned):**
  - next cycle imemAddr=0x100 and out* = bubble;
  - the cycle after, outPc=0x100.
- **Stall held 3 cycles at PC 0x20:** imemAddr stays 0x20 and outPc stays 0x1C for 3 cycles; the next cycle outPc=0x20.
- **Redirect and stall both high:** the redirect wins; pc takes redirectPc and a bubble is issued.
- **Train updatePc=0x40, taken, target 0x80:**
  - entry allocated with counter 2'b10; next fetch of 0x40 predicts taken, imemAddr goes 0x40→0x80, outPredTaken=1;
  - two not-taken updates then drop the counter to 2'b00, and 0x40 falls through to 0x44.
- **Aliasing with BTB_ENTRIES=16:**
  - train 0x40 taken; a fetch of 0x80 (same index 0, different tag) predicts not-taken;
  - a taken update at 0x80 then evicts 0x40, and a fetch of 0x40 predicts not-taken.
